lfsr_gen: RTL

- Parametrised successor to the team's fixed 16-bit seeded LFSR.
- Width, tap polynomial, structure (Fibonacci or Galois) and steps per clock are all parameters.
- Adds a synchronous seed load, a step enable, zero-seed protection and period measurement.
- Used as the pseudo-random source and self-checking pattern generator across assignment testbenches and datapaths.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_step.sv | 28 ++
 rtl/lfsr_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the parametrised LFSR generator: structure selectors
// and maximal-length tap masks for the common widths.
package lfsr_pkg;

   localparam int MODE_FIB = 0;
   localparam int MODE_GAL = 1;

   localparam logic [3:0]  TAPS4  = 4'hC;
   localparam logic [7:0]  TAPS8  = 8'hB8;
   localparam logic [15:0] TAPS16 = 16'hB400;
   localparam logic [31:0] TAPS32 = 32'h80200003;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR shift, Fibonacci or Galois.
// Latency: none. Backpressure: none, pure function of the input state.
// Tap bits at or above WIDTH are dropped.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int          WIDTH = 16,
   parameter logic [31:0] TAPS  = 32'h0000_B400,
   parameter int          MODE  = MODE_FIB
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next_state,
   output logic             shifted
);

   localparam logic [WIDTH-1:0] TMASK = TAPS[WIDTH-1:0];

   generate
      if (MODE == MODE_GAL) begin : g_gal
         assign shifted    = state[0];
         assign next_state = (state >> 1) ^ (state[0] ? TMASK : '0);
      end else begin : g_fib
         assign shifted    = state[WIDTH-1];
         assign next_state = {state[WIDTH-2:0], ^(state & TMASK)};
      end
   endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with seed load, zero-seed substitution and period measurement.
// Latency: one clock from en/load to state; all outputs registered.
// Backpressure: none; en gates advance, load has priority over en.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int          WIDTH        = 16,
   parameter logic [31:0] TAPS         = 32'h0000_B400,
   parameter int          MODE         = MODE_FIB,
   parameter int          STEPS        = 1,
   parameter logic [31:0] SEED_DEFAULT = 32'd1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] state,
   output logic [STEPS-1:0] bits_out,
   output logic             seed_err,
   output logic             period_done,
   output logic [WIDTH-1:0] period_len
);

   localparam logic [WIDTH-1:0] SEED_DEF = SEED_DEFAULT[WIDTH-1:0];

   logic [WIDTH-1:0] chain [STEPS+1];
   logic [STEPS-1:0] shifted;
   logic [WIDTH-1:0] ref_seed;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] seed_sel;

   assign chain[0] = state;

   generate
      for (genvar g = 0; g < STEPS; g++) begin : g_chain
         lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .MODE  (MODE)
         ) u_step (
            .state      (chain[g]),
            .next_state (chain[g+1]),
            .shifted    (shifted[g])
         );
      end
   endgenerate

   // A zero seed would lock the register at zero forever, so substitute.
   assign seed_sel = (seed == '0) ? SEED_DEF : seed;
   assign cnt_inc  = (&cnt) ? cnt : cnt + WIDTH'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SEED_DEF;
         ref_seed    <= SEED_DEF;
         cnt         <= '0;
         bits_out    <= '0;
         seed_err    <= 1'b0;
         period_done <= 1'b0;
         period_len  <= '0;
      end else begin
         seed_err    <= 1'b0;
         period_done <= 1'b0;
         if (load) begin
            state    <= seed_sel;
            ref_seed <= seed_sel;
            cnt      <= '0;
            seed_err <= (seed == '0);
         end else if (en) begin
            state    <= chain[STEPS];
            bits_out <= shifted;
            // Only the post-cycle state is compared; intermediate steps are not.
            if (chain[STEPS] == ref_seed) begin
               period_done <= 1'b1;
               period_len  <= cnt_inc;
               cnt         <= '0;
            end else begin
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule
